ula_multiciclo: RTL

//  Parametrised successor of the datapath's combinational 32-bit ALU, for the multicycle MIPS core.

---
 rtl/ula_multiciclo_if.sv | 29 ++
 rtl/ula_multiciclo.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/ula_multiciclo_if.sv
// Request/response bundle between the multicycle control unit (master) and the ALU (slave).
// Operands and op are presented with in_valid; results come back with a one-cycle done pulse.
interface ula_multiciclo_if #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int OP_W    = 5
);
  logic               in_valid;
  logic [OP_W-1:0]    op;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [SHAMT_W-1:0] shamt;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   s;
  logic               z;
  logic               ovf;
  logic               dz;

  modport master (
    output in_valid, op, a, b, shamt,
    input  busy, done, s, z, ovf, dz
  );

  modport slave (
    input  in_valid, op, a, b, shamt,
    output busy, done, s, z, ovf, dz
  );
endinterface

// File: rtl/ula_multiciclo.sv
// Multicycle ALU: single-cycle logic/arith/shift ops plus iterative shift-add multiply and
// restoring divide into internal HI/LO, with a valid/busy/done handshake for the control unit.
module ula_multiciclo #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH),
  parameter int OP_W    = 5
) (
  input  logic             clock,
  input  logic             reset_n,
  ula_multiciclo_if.slave  bus
);

  localparam logic [OP_W-1:0] OP_AND   = OP_W'(0);
  localparam logic [OP_W-1:0] OP_OR    = OP_W'(1);
  localparam logic [OP_W-1:0] OP_ADD   = OP_W'(2);
  localparam logic [OP_W-1:0] OP_PASSA = OP_W'(3);
  localparam logic [OP_W-1:0] OP_SEQ   = OP_W'(4);
  localparam logic [OP_W-1:0] OP_SNE   = OP_W'(5);
  localparam logic [OP_W-1:0] OP_SUB   = OP_W'(6);
  localparam logic [OP_W-1:0] OP_SLT   = OP_W'(7);
  localparam logic [OP_W-1:0] OP_LUI   = OP_W'(8);
  localparam logic [OP_W-1:0] OP_SLL   = OP_W'(9);
  localparam logic [OP_W-1:0] OP_SRL   = OP_W'(10);
  localparam logic [OP_W-1:0] OP_NOR   = OP_W'(11);
  localparam logic [OP_W-1:0] OP_SRA   = OP_W'(12);
  localparam logic [OP_W-1:0] OP_MULT  = OP_W'(13);
  localparam logic [OP_W-1:0] OP_MULTU = OP_W'(14);
  localparam logic [OP_W-1:0] OP_DIV   = OP_W'(15);
  localparam logic [OP_W-1:0] OP_DIVU  = OP_W'(16);
  localparam logic [OP_W-1:0] OP_MFHI  = OP_W'(17);
  localparam logic [OP_W-1:0] OP_MFLO  = OP_W'(18);
  localparam logic [OP_W-1:0] OP_SLTU  = OP_W'(19);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state_q;
  logic [SHAMT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0]   acc_q;     // mul: {partial, multiplier}; div: {remainder, quotient}
  logic [WIDTH-1:0]     opnd_q;    // multiplicand or divisor magnitude
  logic                 is_div_q;
  logic                 div0_q;
  logic                 neg_q;     // negate product / quotient
  logic                 rneg_q;    // negate remainder
  logic [WIDTH-1:0]     hi_q, lo_q;
  logic [WIDTH-1:0]     s_q;
  logic                 z_q, ovf_q, dz_q, done_q, busy_q;

  logic [WIDTH-1:0]     res_d;
  logic                 z_d, ovf_d;
  logic                 is_iter, is_div, is_signed;
  logic                 a_neg, b_neg;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH-1:0]     sum, diff;
  logic [WIDTH:0]       mul_upper, rem_sh, trial;
  logic [2*WIDTH-1:0]   step_d, prod;
  logic [WIDTH-1:0]     fin_hi_d, fin_lo_d;
  logic                 fin_z_d;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    res_d = '0;
    ovf_d = 1'b0;
    z_d   = 1'b0;
    sum   = bus.a + bus.b;
    diff  = bus.a - bus.b;
    case (bus.op)
      OP_AND:   res_d = bus.a & bus.b;
      OP_OR:    res_d = bus.a | bus.b;
      OP_ADD: begin
        res_d = sum;
        ovf_d = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_PASSA: res_d = bus.a;
      OP_SUB: begin
        res_d = diff;
        ovf_d = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SLT:   res_d = WIDTH'($signed(bus.a) < $signed(bus.b));
      OP_LUI:   res_d = bus.b << (WIDTH / 2);
      OP_SLL:   res_d = bus.a << bus.shamt;
      OP_SRL:   res_d = bus.a >> bus.shamt;
      OP_NOR:   res_d = ~(bus.a | bus.b);
      OP_SRA:   res_d = $signed(bus.a) >>> bus.shamt;
      OP_MFHI:  res_d = hi_q;
      OP_MFLO:  res_d = lo_q;
      OP_SLTU:  res_d = WIDTH'(bus.a < bus.b);
      default:  res_d = '0;
    endcase
    // Compare ops report through z with a zero result; everything else flags a zero result.
    if (bus.op == OP_SEQ)      z_d = (bus.a == bus.b);
    else if (bus.op == OP_SNE) z_d = (bus.a != bus.b);
    else                       z_d = (res_d == '0);
  end

  always_comb begin
    is_div    = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
    is_iter   = is_div || (bus.op == OP_MULT) || (bus.op == OP_MULTU);
    is_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    a_neg     = is_signed && bus.a[WIDTH-1];
    b_neg     = is_signed && bus.b[WIDTH-1];
    a_mag     = a_neg ? -bus.a : bus.a;
    b_mag     = b_neg ? -bus.b : bus.b;

    mul_upper = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    rem_sh    = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    trial     = rem_sh - {1'b0, opnd_q};
    // A clear borrow bit means the trial subtraction fit, so that quotient bit is 1.
    if (is_div_q)
      step_d = {trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0],
                acc_q[WIDTH-2:0], ~trial[WIDTH]};
    else
      step_d = {mul_upper, acc_q[WIDTH-1:1]};

    prod = neg_q ? -step_d : step_d;
    if (div0_q) begin
      fin_hi_d = acc_q[2*WIDTH-1:WIDTH];
      fin_lo_d = acc_q[WIDTH-1:0];
    end else if (is_div_q) begin
      fin_hi_d = rneg_q ? -step_d[2*WIDTH-1:WIDTH] : step_d[2*WIDTH-1:WIDTH];
      fin_lo_d = neg_q ? -step_d[WIDTH-1:0] : step_d[WIDTH-1:0];
    end else begin
      fin_hi_d = prod[2*WIDTH-1:WIDTH];
      fin_lo_d = prod[WIDTH-1:0];
    end
    fin_z_d = is_div_q ? (fin_lo_d == '0) : ({fin_hi_d, fin_lo_d} == '0);
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      div0_q   <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      s_q      <= '0;
      z_q      <= 1'b0;
      ovf_q    <= 1'b0;
      dz_q     <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          state_q <= IDLE;
          if (bus.in_valid) begin
            if (is_iter) begin
              state_q  <= RUN;
              busy_q   <= 1'b1;
              cnt_q    <= SHAMT_W'(WIDTH - 1);
              is_div_q <= is_div;
              neg_q    <= a_neg ^ b_neg;
              rneg_q   <= a_neg;
              div0_q   <= is_div && (bus.b == '0);
              if (is_div && (bus.b == '0)) acc_q <= {bus.a, {WIDTH{1'b1}}};
              else if (is_div)             acc_q <= {{WIDTH{1'b0}}, a_mag};
              else                         acc_q <= {{WIDTH{1'b0}}, b_mag};
              opnd_q   <= is_div ? b_mag : a_mag;
            end else begin
              state_q <= DONE;
              s_q     <= res_d;
              z_q     <= z_d;
              ovf_q   <= ovf_d;
              dz_q    <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (div0_q || cnt_q == '0) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            div0_q  <= 1'b0;
            hi_q    <= fin_hi_d;
            lo_q    <= fin_lo_d;
            s_q     <= fin_lo_d;
            z_q     <= fin_z_d;
            ovf_q   <= 1'b0;
            dz_q    <= div0_q;
          end else begin
            acc_q <= step_d;
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.s    = s_q;
  assign bus.z    = z_q;
  assign bus.ovf  = ovf_q;
  assign bus.dz   = dz_q;

endmodule
